dht11_reader: RTL



---
 rtl/dht11_reader.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/dht11_reader.sv
// DHT11 single-wire master: issues the host start pulse, decodes the 40-bit
// sensor frame and commits humidity/temperature bytes when the checksum matches.
module dht11_reader #(
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int START_LOW_US  = 20000,
  parameter int TIMEOUT_US    = 100,
  parameter int BIT_THRESH_US = 40
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  inout  wire        dht_data,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] humi_int,
  output logic [7:0] humi_float,
  output logic [7:0] temp_int,
  output logic [7:0] temp_float
);

  localparam int TICK_DIV = (CLK_FREQ_HZ / 1_000_000 > 0) ? CLK_FREQ_HZ / 1_000_000 : 1;
  localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE, START_LOW, RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK
  } state_t;

  state_t             state_reg, state_next;
  logic [PRE_W-1:0]   pre_cnt_reg;
  logic [15:0]        us_cnt_reg, us_cnt_next;
  logic [5:0]         bit_cnt_reg, bit_cnt_next;
  logic [39:0]        shift_reg, shift_next;
  logic               sync1_reg, sync2_reg, prev_reg;
  logic               drive_low_reg, drive_low_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               error_reg, error_next;
  logic [7:0]         humi_int_reg, humi_int_next;
  logic [7:0]         humi_float_reg, humi_float_next;
  logic [7:0]         temp_int_reg, temp_int_next;
  logic [7:0]         temp_float_reg, temp_float_next;
  logic               tick, rise, fall, timeout;
  logic [7:0]         checksum_calc;

  assign tick          = (pre_cnt_reg == PRE_W'(TICK_DIV - 1));
  assign rise          = sync2_reg & ~prev_reg;
  assign fall          = ~sync2_reg & prev_reg;
  assign timeout       = (us_cnt_reg >= 16'(TIMEOUT_US));
  assign checksum_calc = shift_reg[39:32] + shift_reg[31:24] + shift_reg[23:16] + shift_reg[15:8];

  // Open-drain: only ever pull low or release.
  assign dht_data   = drive_low_reg ? 1'b0 : 1'bz;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign error      = error_reg;
  assign humi_int   = humi_int_reg;
  assign humi_float = humi_float_reg;
  assign temp_int   = temp_int_reg;
  assign temp_float = temp_float_reg;

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    done_next       = 1'b0;
    error_next      = error_reg;
    humi_int_next   = humi_int_reg;
    humi_float_next = humi_float_reg;
    temp_int_next   = temp_int_reg;
    temp_float_next = temp_float_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next   = START_LOW;
          error_next   = 1'b0;
          bit_cnt_next = '0;
        end
      end
      START_LOW: if (us_cnt_reg >= 16'(START_LOW_US)) state_next = RELEASE;
      RELEASE: begin
        if (fall) state_next = RESP_LOW;
        else if (timeout) begin state_next = IDLE; error_next = 1'b1; end
      end
      RESP_LOW: begin
        if (rise) state_next = RESP_HIGH;
        else if (timeout) begin state_next = IDLE; error_next = 1'b1; end
      end
      RESP_HIGH: begin
        if (fall) state_next = BIT_LOW;
        else if (timeout) begin state_next = IDLE; error_next = 1'b1; end
      end
      BIT_LOW: begin
        if (rise) state_next = BIT_HIGH;
        else if (timeout) begin state_next = IDLE; error_next = 1'b1; end
      end
      BIT_HIGH: begin
        if (fall) begin
          shift_next   = {shift_reg[38:0], (us_cnt_reg > 16'(BIT_THRESH_US))};
          bit_cnt_next = bit_cnt_reg + 6'd1;
          state_next   = (bit_cnt_reg == 6'd39) ? CHECK : BIT_LOW;
        end else if (timeout) begin
          state_next = IDLE;
          error_next = 1'b1;
        end
      end
      CHECK: begin
        state_next = IDLE;
        if (checksum_calc == shift_reg[7:0]) begin
          done_next       = 1'b1;
          humi_int_next   = shift_reg[39:32];
          humi_float_next = shift_reg[31:24];
          temp_int_next   = shift_reg[23:16];
          temp_float_next = shift_reg[15:8];
        end else begin
          error_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    busy_next      = (state_next != IDLE);
    drive_low_next = (state_next == START_LOW);
    // The entry cycle's tick is counted so a W us pulse measures exactly W.
    if (state_next == IDLE)
      us_cnt_next = '0;
    else if (state_next != state_reg)
      us_cnt_next = {15'd0, tick};
    else
      us_cnt_next = us_cnt_reg + {15'd0, tick};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      pre_cnt_reg    <= '0;
      us_cnt_reg     <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      sync1_reg      <= 1'b1;
      sync2_reg      <= 1'b1;
      prev_reg       <= 1'b1;
      drive_low_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
      humi_int_reg   <= '0;
      humi_float_reg <= '0;
      temp_int_reg   <= '0;
      temp_float_reg <= '0;
    end else begin
      state_reg      <= state_next;
      pre_cnt_reg    <= tick ? '0 : pre_cnt_reg + PRE_W'(1);
      us_cnt_reg     <= us_cnt_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      sync1_reg      <= dht_data;
      sync2_reg      <= sync1_reg;
      prev_reg       <= sync2_reg;
      drive_low_reg  <= drive_low_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      error_reg      <= error_next;
      humi_int_reg   <= humi_int_next;
      humi_float_reg <= humi_float_next;
      temp_int_reg   <= temp_int_next;
      temp_float_reg <= temp_float_next;
    end
  end

endmodule
